fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage placed directly upstream of the decoder in the rv32i core. It keeps the fetch PC, issues word requests to instruction memory over a request/grant/response bus, buffers returned words with their PCs in a small FIFO, and presents them to the decode stage via a valid/ready handshake. A redirect (branch/jump from execute) flushes buffered and in-flight fetches and restarts at the new PC.

## Interface

Parameters:
- RESET_PC, 32'h8000_0000, fetch address after reset.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; 1..DEPTH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  request valid.
- imem_addr  out  32  request word address, bits [1:0] always 00.
- imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req).
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  response instruction word.
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decoder accepts head.
- instr_data  out  32  head instruction word.
- instr_pc  out  32  head PC.
- instr_fault  out  1  head is a misaligned-redirect fault entry (see Configuration).

## Operation

- Registers: fetch_pc (next address to request), resp_pc (PC of next response to keep), outstanding count, discard count, FIFO (pc, data, fault), state {RUN, HALT}.
- imem_req = state==RUN && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < DEPTH; imem_addr = fetch_pc.
- Bus permits abandonment: a request not yet granted may change address or drop.
- Grant (imem_req && imem_gnt): fetch_pc += 4, outstanding += 1.
- Response: outstanding -= 1; if discard > 0, drop word and discard -= 1; else push {resp_pc, imem_rdata, 0}, resp_pc += 4.
- Grant and response same cycle: outstanding unchanged.
- Pop when instr_valid && instr_ready.
- Redirect (highest priority): FIFO flushed; fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}; discard = outstanding + grant_this_cycle − response_this_cycle − (discard if response was already being discarded: new discard = all requests still unanswered after this edge); state = RUN. Response arriving in the redirect cycle is dropped. Pop in the redirect cycle is ignored.
- Arithmetic: PCs wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Full: no request issued when outstanding + fifo_count == DEPTH, so every response always has a slot; push to full FIFO cannot occur.

## Timing

- Reset values: imem_req 0 during reset, fetch_pc = resp_pc = RESET_PC, outstanding = discard = 0, FIFO empty, instr_valid 0, instr_data 0, instr_pc 0, instr_fault 0, state RUN.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Zero-wait memory (gnt same cycle, rvalid next cycle): request cycle N, response N+1, instr_valid N+2. Steady throughput one instruction per cycle with MAX_OUTSTANDING >= 2.
- Redirect at cycle N: imem_addr = redirect target at N+1; instr_valid 0 at N+1; earliest new instr_valid at N+3.
- Reset mid-operation clears everything; instruction memory shares reset_n, no stale responses expected afterwards.

## Configuration

- FETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0] != 00 flushes as normal, pushes one entry {pc=redirect_pc unmodified, data=0, fault=1}, sets state HALT (no requests; in-flight responses still discarded) until the next redirect.
- Not defined: redirect_pc[1:0] ignored (forced 00), state never HALT, instr_fault tied 0.

## Test plan

- Reset release, zero-wait memory returning addr as data, instr_ready=1 -> instr_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles from cycle 2, instr_data equal to PC.
- instr_ready=0 for 20 cycles -> exactly DEPTH=4 entries accepted, imem_req low afterwards; release -> 8000_0000..8000_000C popped in order, fetch resumes at 8000_0010.
- Responses delayed 3 cycles, redirect to 0000_0100 while 2 outstanding -> both stale responses dropped, next instr_pc 0000_0100.
- Redirect simultaneous with grant and response -> granted request's response also discarded; no stale PC ever appears.
- fetch_pc at FFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_MISALIGN_CHK_EN, redirect to 0000_0102 -> one entry instr_fault=1, instr_pc 0000_0102, no imem_req until redirect to 0000_0200 resumes fetch; without macro -> fetch at 0000_0100, instr_fault 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/grant/response bus, redirect
// input and decode-side valid/ready handshake for the rv32i fetch stage.
// The master modport is the fetch unit's view; slave is the environment
// (instruction memory, execute redirect and decoder).
interface fetch_unit_if;
    // instruction memory bus
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // redirect from execute
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    // decode handshake
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output instr_fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  instr_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction fetch stage. Keeps the fetch PC, issues
// in-order word requests, buffers responses with their PCs in a small FIFO
// and presents them to decode. A redirect flushes the FIFO, marks every
// in-flight request for discard and restarts at the new PC.
// Optional feature macro FETCH_MISALIGN_CHK_EN: a redirect to a non-word-
// aligned PC pushes a single fault entry and halts fetch until the next
// redirect. Without it the low two redirect bits are ignored.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    localparam int unsigned PTR_W            = $clog2(DEPTH);
    localparam int unsigned CNT_W            = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W            = CNT_W + 1;
    localparam logic [31:0] PC_MASK          = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_MASK;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } entry_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    entry_t           fifo_mem [DEPTH];

    logic [31:0]      redirect_target;
    logic             misalign;
    logic             grant;
    logic             resp;
    logic             keep_resp;
    logic             pop;
    logic             push;
    logic [PTR_W-1:0] push_idx;
    entry_t           push_entry;
    entry_t           head;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] fifo_count_next;
    logic [SUM_W-1:0] in_use;

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Requests stop once every FIFO slot is either filled or reserved by an
    // in-flight request, so a response can always be absorbed.
    assign in_use        = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign bus.imem_req  = reset_n
                        && (state == RUN)
                        && (outstanding < CNT_W'(MAX_OUTSTANDING))
                        && (in_use < SUM_W'(DEPTH));
    assign bus.imem_addr = fetch_pc;

    // Head of FIFO to decode; fields read as zero when nothing is valid.
    assign head             = fifo_mem[rd_ptr];
    assign bus.instr_valid  = (fifo_count != '0);
    assign bus.instr_pc     = bus.instr_valid ? head.pc   : 32'h0;
    assign bus.instr_data   = bus.instr_valid ? head.data : 32'h0;
    assign bus.instr_fault  = bus.instr_valid & head.fault;

    // Handshake qualifiers, FIFO write selection and next counter values.
    always_comb begin
        grant           = bus.imem_req && bus.imem_gnt;
        resp            = bus.imem_rvalid;
        keep_resp       = resp && (discard == '0);
        pop             = bus.instr_valid && bus.instr_ready;
        redirect_target = bus.redirect_pc & PC_MASK;

        outstanding_next = outstanding;
        if (grant && !resp) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!grant && resp) begin
            outstanding_next = outstanding - CNT_W'(1);
        end

        push       = 1'b0;
        push_idx   = wr_ptr;
        push_entry = '0;
        if (bus.redirect_valid) begin
            // only a misaligned redirect writes, into the freshly flushed slot 0
            push       = misalign;
            push_idx   = '0;
            push_entry = '{pc: bus.redirect_pc, data: 32'h0, fault: 1'b1};
        end else if (keep_resp) begin
            push       = 1'b1;
            push_entry = '{pc: resp_pc, data: bus.imem_rdata, fault: 1'b0};
        end

        fifo_count_next = fifo_count;
        if (push && !pop) begin
            fifo_count_next = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_count_next = fifo_count - CNT_W'(1);
        end
    end

    // Fetch state, PCs, bus bookkeeping and FIFO pointers; redirect wins over
    // responses and pops but outstanding still tracks the real bus.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC_ALIGNED;
            resp_pc     <= RESET_PC_ALIGNED;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                // every request still unanswered after this edge is stale
                fetch_pc   <= redirect_target;
                resp_pc    <= redirect_target;
                discard    <= outstanding_next;
                rd_ptr     <= '0;
                wr_ptr     <= misalign ? PTR_W'(1) : PTR_W'(0);
                fifo_count <= misalign ? CNT_W'(1) : CNT_W'(0);
                state      <= misalign ? HALT : RUN;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp) begin
                    if (discard != '0) begin
                        discard <= discard - CNT_W'(1);
                    end else begin
                        resp_pc <= resp_pc + 32'd4;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count_next;
            end
        end
    end

    // FIFO storage; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_mem[push_idx] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit. An in-order memory model
// answers granted requests after a random latency; a scoreboard holds the
// instruction stream the decoder must see (sequential PCs from the latest
// restart point), and a monitor compares every accepted instruction.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    int          grants = 0;
    int          over_max = 0;
    int unsigned cyc    = 0;
    int          gnt_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] salt   = 32'h0;
    mreq_t       mq[$];
    exp_t        exp_q[$];
    exp_t        mon_e;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected decode stream after a restart at target.
    function automatic void restart(input logic [31:0] target);
        logic [31:0] pc;
        exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
        if (target[1:0] != 2'b00) begin
            exp_q.push_back('{target, 32'h0, 1'b1});
            return;
        end
`endif
        pc = {target[31:2], 2'b00};
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back('{pc, pc ^ salt, 1'b0});
            pc = pc + 32'd4;
        end
    endfunction

    // Memory drive: random grant, in-order response once due.
    always @(posedge clk) begin
        cyc++;
        #1;
        bus.imem_gnt = ($urandom_range(99) < gnt_pct);
        if (reset_n && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mq[0].addr ^ salt;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
    end

    // Memory sample: retire presented response, record granted request.
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            mq.delete();
        end else begin
            if (bus.imem_rvalid) void'(mq.pop_front());
            if (bus.imem_req && bus.imem_gnt) begin
                mq.push_back('{bus.imem_addr, cyc + $urandom_range(lat_max, lat_min)});
                grants++;
            end
            if (mq.size() > MAX_OUT) over_max++;
        end
    end

    // Monitor: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc 0x%0h data 0x%0h with nothing expected",
                         bus.instr_pc, bus.instr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("instr_stream", {31'd0, bus.instr_fault, bus.instr_pc, bus.instr_data},
                      {31'd0, mon_e.fault, mon_e.pc, mon_e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        restart(pc);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        restart(RESET_PC);
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          g0;
        int          p0;
        int          req_seen;
        int          since;
        logic [31:0] r;

        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b1;
        restart(RESET_PC);

        // reset values
        repeat (3) tick();
        settle();
        check("reset_imem_req",    96'(bus.imem_req),    96'(0));
        check("reset_instr_valid", 96'(bus.instr_valid), 96'(0));
        check("reset_instr_pc",    96'(bus.instr_pc),    96'(0));
        check("reset_instr_data",  96'(bus.instr_data),  96'(0));
        check("reset_instr_fault", 96'(bus.instr_fault), 96'(0));

        // zero-wait memory: request cycle 0, instruction from cycle 2
        tick();
        reset_n = 1'b1;
        settle();
        check("first_req",  96'(bus.imem_req),  96'(1));
        check("first_addr", 96'(bus.imem_addr), 96'(RESET_PC));
        tick();
        settle();
        check("valid_cycle1", 96'(bus.instr_valid), 96'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            check("zero_wait_pc", 96'({bus.instr_valid, bus.instr_pc}),
                  96'({1'b1, RESET_PC + 32'(4 * i)}));
        end

        // decoder stall: FIFO fills to DEPTH, then requests stop
        tick();
        bus.instr_ready = 1'b0;
        do_reset(2);
        g0 = grants;
        repeat (20) tick();
        settle();
        check("stall_grants", 96'(grants - g0), 96'(DEPTH));
        check("stall_req_low", 96'(bus.imem_req), 96'(0));
        check("stall_head", 96'({bus.instr_valid, bus.instr_pc}), 96'({1'b1, RESET_PC}));
        tick();
        p0 = pops;
        bus.instr_ready = 1'b1;
        repeat (12) tick();
        settle();
        check("stall_drain_progress", 96'(pops - p0 >= 6), 96'(1));

        // redirect timing with zero-wait memory
        tick();
        do_redirect(32'h0000_0100);
        settle();
        check("redir_addr_n1",  96'(bus.imem_addr),   96'(32'h0000_0100));
        check("redir_flush_n1", 96'(bus.instr_valid), 96'(0));
        tick();
        settle();
        check("redir_valid_n2", 96'(bus.instr_valid), 96'(0));
        tick();
        settle();
        check("redir_first_n3", 96'({bus.instr_valid, bus.instr_pc}), 96'({1'b1, 32'h0000_0100}));

        // slow memory: redirect while requests are in flight
        tick();
        lat_min = 3;
        lat_max = 3;
        repeat (10) tick();
        p0 = pops;
        do_redirect(32'h0000_0100);
        repeat (20) tick();
        settle();
        check("delay_redirect_progress", 96'(pops - p0 >= 3), 96'(1));

        // PC wrap at the top of the address space
        tick();
        lat_min = 1;
        lat_max = 1;
        p0 = pops;
        do_redirect(32'hFFFF_FFF8);
        repeat (10) tick();
        settle();
        check("wrap_progress", 96'(pops - p0 >= 3), 96'(1));

        // misaligned redirect
        tick();
        p0 = pops;
        do_redirect(32'h0000_0102);
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (bus.imem_req) req_seen++;
            tick();
        end
`ifdef FETCH_MISALIGN_CHK_EN
        check("halt_no_req",    96'(req_seen),  96'(0));
        check("halt_one_entry", 96'(pops - p0), 96'(1));
        p0 = pops;
        do_redirect(32'h0000_0200);
        repeat (10) tick();
        settle();
        check("halt_resume", 96'(pops - p0 >= 3), 96'(1));
`else
        check("misalign_req_continues", 96'(req_seen), 96'(10));
        check("misalign_progress", 96'(pops - p0 >= 3), 96'(1));
`endif

        // randomized traffic with redirects and one mid-run reset
        tick();
        salt = 32'h5A3C_96E1;
        do_reset(2);
        p0    = pops;
        since = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                gnt_pct = $urandom_range(100, 30);
                lat_min = 1;
                lat_max = $urandom_range(4, 1);
            end
            bus.instr_ready = ($urandom_range(99) < 70);
            if (c == 1500) begin
                do_reset(2);
                since = 0;
            end else if (since > 150 || $urandom_range(99) < 3) begin
                r = $urandom;
                case ($urandom_range(9))
                    0:       r = 32'hFFFF_FFE0 | (r & 32'h0000_001F);
                    1, 2:    r = r;
                    default: r = r & 32'hFFFF_FFFC;
                endcase
                do_redirect(r);
                since = 0;
            end else begin
                tick();
                since++;
            end
        end
        settle();
        check("random_progress", 96'(pops - p0 >= 300), 96'(1));
        check("max_outstanding", 96'(over_max), 96'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
